// File: rtl/gshare_predict.sv
// Global-history branch direction predictor: a PHT of saturating counters, a speculative GHR
// updated at fetch and an architectural GHR updated at M. Define GSHARE_PC_XOR_EN for gshare.
module gshare_predict #(
    parameter int PC_WIDTH       = 32,
    parameter int GHR_BITS       = 8,
    parameter int PHT_INDEX_BITS = 10,
    parameter int CTR_BITS       = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stallD,
    input  logic                      flushD,
    input  logic [PC_WIDTH-1:0]       pcF,
    input  logic                      branchF,
    input  logic                      branchD,
    input  logic                      branchM,
    input  logic                      actual_takeM,
    input  logic                      errorM,
    input  logic [PHT_INDEX_BITS-1:0] pht_idxM,
    output logic                      pred_takeD,
    output logic [PHT_INDEX_BITS-1:0] pht_idxD,
    output logic [GHR_BITS-1:0]       ghr_spec,
    output logic [CNT_WIDTH-1:0]      branch_cnt,
    output logic [CNT_WIDTH-1:0]      mispred_cnt
);

    localparam int                   PHT_ENTRIES = 1 << PHT_INDEX_BITS;
    localparam logic [CTR_BITS-1:0]  CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0]  CTR_WEAK    = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic [CTR_BITS-1:0]       pht_q [PHT_ENTRIES];
    logic [CTR_BITS-1:0]       ctr_cur;
    logic [CTR_BITS-1:0]       ctr_upd;

    logic [PHT_INDEX_BITS-1:0] idx_f;
    logic                      pred_take_f;

    logic                      pred_q, pred_d;
    logic [PHT_INDEX_BITS-1:0] idx_q, idx_d;
    logic [GHR_BITS-1:0]       ghr_spec_q, ghr_spec_d;
    logic [GHR_BITS-1:0]       ghr_arch_q, ghr_arch_d;
    logic [CNT_WIDTH-1:0]      branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]      mispred_cnt_q, mispred_cnt_d;

    logic                      unused_pc;

`ifdef GSHARE_PC_XOR_EN
    assign idx_f = PHT_INDEX_BITS'(ghr_spec_q) ^ pcF[PHT_INDEX_BITS+1:2];
`else
    assign idx_f = PHT_INDEX_BITS'(ghr_spec_q);
`endif
    // Only a slice of pcF feeds the index (none of it in GAg mode).
    assign unused_pc = ^pcF;

    // Read is combinational and sees the pre-update counter when M writes the same entry.
    assign pred_take_f = pht_q[idx_f][CTR_BITS-1];

    assign ctr_cur = pht_q[pht_idxM];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        ctr_upd = ctr_cur;
        if (actual_takeM) begin
            if (ctr_cur != CTR_MAX) ctr_upd = ctr_cur + CTR_BITS'(1);
        end else begin
            if (ctr_cur != '0) ctr_upd = ctr_cur - CTR_BITS'(1);
        end
    end

    always_comb begin
        pred_d        = pred_q;
        idx_d         = idx_q;
        ghr_spec_d    = ghr_spec_q;
        ghr_arch_d    = ghr_arch_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (flushD) begin
            pred_d = 1'b0;
            idx_d  = '0;
        end else if (!stallD) begin
            pred_d = pred_take_f;
            idx_d  = idx_f;
        end

        // Repair beats a fetch-side shift; the F instruction is flushed by the pipeline anyway.
        if (errorM) begin
            ghr_spec_d = {ghr_arch_q[GHR_BITS-2:0], actual_takeM};
        end else if (branchF && !stallD && !flushD) begin
            ghr_spec_d = {ghr_spec_q[GHR_BITS-2:0], pred_take_f};
        end

        if (branchM) begin
            ghr_arch_d = {ghr_arch_q[GHR_BITS-2:0], actual_takeM};
            if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            if (errorM && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q        <= 1'b0;
            idx_q         <= '0;
            ghr_spec_q    <= '0;
            ghr_arch_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pred_q        <= pred_d;
            idx_q         <= idx_d;
            ghr_spec_q    <= ghr_spec_d;
            ghr_arch_q    <= ghr_arch_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // NOTE: the PHT is a flop array, so it can be reset to weakly-taken; a RAM macro could not be.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_WEAK;
        end else if (branchM) begin
            pht_q[pht_idxM] <= ctr_upd;
        end
    end

    assign pred_takeD  = branchD & pred_q;
    assign pht_idxD    = idx_q;
    assign ghr_spec    = ghr_spec_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_gshare_predict.sv
// Directed bench for gshare_predict: stimulus pushes hand-computed expectations into a
// scoreboard queue; a negedge monitor pops and compares them in the cycle they fall due.
module tb_gshare_predict;

    localparam logic [31:0] PC0    = 32'h0040_0000;  // index bits [11:2] are zero
    localparam logic [31:0] PC_T1  = 32'h0040_0010;
    localparam logic [31:0] PC_SAT = 32'h0040_0C00;  // bits [11:2] = 0x300
    localparam logic [31:0] PC_OFF = 32'hFFFF_FFFC;
`ifdef GSHARE_PC_XOR_EN
    localparam logic [9:0] I1_IDX  = 10'h004;
    localparam logic [9:0] SAT_IDX = 10'h3FF;        // 0x0FF ^ 0x300
    localparam logic [9:0] OFF_IDX = 10'h3FC;        // 0x003 ^ 0x3FF
`else
    localparam logic [9:0] I1_IDX  = 10'h000;
    localparam logic [9:0] SAT_IDX = 10'h0FF;
    localparam logic [9:0] OFF_IDX = 10'h003;
`endif

    logic        clk = 1'b0;
    logic        rst, stallD, flushD, branchF, branchD, branchM, actual_takeM, errorM;
    logic [31:0] pcF;
    logic [9:0]  pht_idxM;
    logic        pred_takeD;
    logic [9:0]  pht_idxD;
    logic [7:0]  ghr_spec;
    logic [31:0] branch_cnt, mispred_cnt;

    gshare_predict dut (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF),
        .branchF(branchF), .branchD(branchD), .branchM(branchM),
        .actual_takeM(actual_takeM), .errorM(errorM), .pht_idxM(pht_idxM),
        .pred_takeD(pred_takeD), .pht_idxD(pht_idxD), .ghr_spec(ghr_spec),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {F_PRED, F_IDX, F_GHR, F_BCNT, F_MCNT} field_e;
    typedef struct {
        int          due;
        field_e      fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        cur;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            case (cur.fld)
                F_PRED:  act = 32'(pred_takeD);
                F_IDX:   act = 32'(pht_idxD);
                F_GHR:   act = 32'(ghr_spec);
                F_BCNT:  act = branch_cnt;
                default: act = mispred_cnt;
            endcase
            n_cmp++;
            if (cur.due != cyc || act !== cur.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h want 0x%0h (due %0d, cycle %0d)",
                         cur.name, act, cur.val, cur.due, cyc);
            end
        end
    end

    task automatic check(input logic [31:0] got, input logic [31:0] want, input string nm);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input field_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.due  = cyc + 1;
        e.fld  = f;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic set_idle();
        rst = 1'b0; stallD = 1'b0; flushD = 1'b0; branchF = 1'b0; branchD = 1'b1;
        branchM = 1'b0; actual_takeM = 1'b0; errorM = 1'b0; pht_idxM = '0; pcF = PC0;
    endtask

    task automatic m_update(input logic take, input logic [9:0] idx);
        set_idle();
        branchM = 1'b1; actual_takeM = take; pht_idxM = idx;
    endtask

    initial begin
        logic [7:0] arch_bits;
        set_idle();
        rst = 1'b1;
        tick();
        push_exp(F_PRED, 0, "rst_pred");
        push_exp(F_IDX,  0, "rst_idx");
        push_exp(F_GHR,  0, "rst_ghr");
        push_exp(F_BCNT, 0, "rst_bcnt");
        push_exp(F_MCNT, 0, "rst_mcnt");
        tick();

        // Reset prediction: weakly-taken PHT predicts taken, history shifts in a 1.
        set_idle(); branchF = 1'b1; pcF = PC_T1;
        push_exp(F_PRED, 1, "t1_pred");
        push_exp(F_IDX,  32'(I1_IDX), "t1_idx");
        push_exp(F_GHR,  32'h01, "t1_ghr");
        tick();
        set_idle(); tick();

        // Not-taken training at index 5: 2 -> 1 -> 0 -> 0.
        m_update(1'b0, 10'h005); tick();
        m_update(1'b0, 10'h005); tick();
        m_update(1'b0, 10'h005);
        push_exp(F_BCNT, 3, "nt_bcnt");
        tick();

        // Build ghr_arch = 0x02, then repair without branchM to put 0x05 in ghr_spec.
        m_update(1'b1, 10'h200); tick();
        m_update(1'b0, 10'h201); tick();
        set_idle(); errorM = 1'b1; actual_takeM = 1'b1;
        push_exp(F_GHR,  32'h05, "rep_only_ghr");
        push_exp(F_BCNT, 5, "rep_only_bcnt");
        push_exp(F_MCNT, 0, "rep_only_mcnt");
        tick();
        set_idle();
        push_exp(F_PRED, 0, "nt_pred");
        push_exp(F_IDX,  5, "nt_idx");
        tick();

        // Taken saturation at SAT_IDX (2 -> 3, held), one decrement to 2.
        for (int i = 0; i < 4; i++) begin m_update(1'b1, SAT_IDX); tick(); end
        m_update(1'b0, SAT_IDX); tick();
        // Seven taken updates leave ghr_arch[6:0] = 0x7F; repair then gives ghr_spec = 0xFF.
        for (int i = 0; i < 7; i++) begin m_update(1'b1, 10'h200); tick(); end
        set_idle(); errorM = 1'b1; actual_takeM = 1'b1;
        push_exp(F_GHR,  32'hFF, "sat_ghr");
        push_exp(F_BCNT, 17, "sat_bcnt");
        tick();

        // Same-cycle read and not-taken write: F sees the old counter (2).
        m_update(1'b0, SAT_IDX); pcF = PC_SAT;
        push_exp(F_PRED, 1, "sat_pred_pre");
        push_exp(F_IDX,  32'(SAT_IDX), "sat_idx");
        tick();

        // Eight updates shift ghr_arch to 0x0A (from 0xFE); taken ones go to SAT_IDX.
        arch_bits = 8'b0000_1010;
        for (int i = 7; i >= 0; i--) begin
            m_update(arch_bits[i], arch_bits[i] ? SAT_IDX : 10'h000);
            if (i == 7) begin
                pcF = PC_SAT;
                push_exp(F_PRED, 0, "sat_pred_post");
            end
            tick();
        end

        // Repair priority: errorM beats branchF in the same cycle.
        set_idle(); branchF = 1'b1; errorM = 1'b1; branchM = 1'b1; actual_takeM = 1'b1;
        push_exp(F_GHR,  32'h15, "rep_ghr");
        push_exp(F_MCNT, 1, "rep_mcnt");
        push_exp(F_BCNT, 27, "rep_bcnt");
        push_exp(F_IDX,  32'h0FF, "rep_idx");
        tick();

        // Stall holds the D register and blocks the fetch-side history shift.
        for (int i = 0; i < 3; i++) begin
            set_idle(); stallD = 1'b1; branchF = 1'b1;
            push_exp(F_IDX,  32'h0FF, "stall_idx");
            push_exp(F_GHR,  32'h15, "stall_ghr");
            push_exp(F_PRED, 1, "stall_pred");
            tick();
        end
        set_idle(); stallD = 1'b1; flushD = 1'b1; branchF = 1'b1;
        push_exp(F_PRED, 0, "flush_pred");
        push_exp(F_IDX,  0, "flush_idx");
        push_exp(F_GHR,  32'h15, "flush_ghr");
        tick();

        // Mid-run reset overrides a simultaneous update, repair and fetch.
        set_idle(); rst = 1'b1; branchF = 1'b1; branchM = 1'b1; errorM = 1'b1;
        push_exp(F_PRED, 0, "mrst_pred");
        push_exp(F_IDX,  0, "mrst_idx");
        push_exp(F_GHR,  0, "mrst_ghr");
        push_exp(F_BCNT, 0, "mrst_bcnt");
        push_exp(F_MCNT, 0, "mrst_mcnt");
        tick();

        // PHT[0] was trained down before the reset; it must read weakly taken again.
        set_idle(); branchF = 1'b1;
        push_exp(F_PRED, 1, "mrst_pht_pred");
        push_exp(F_GHR,  32'h01, "mrst_ghr1");
        tick();
        set_idle(); branchF = 1'b1;
        push_exp(F_IDX, 1, "hist_idx");
        push_exp(F_GHR, 32'h03, "hist_ghr");
        tick();

        // PC contribution: ignored in GAg, folded in for gshare.
        set_idle(); pcF = PC_OFF;
        push_exp(F_IDX,  32'(OFF_IDX), "pcxor_idx");
        push_exp(F_GHR,  32'h03, "pcxor_ghr");
        push_exp(F_PRED, 1, "pcxor_pred");
        tick();

        set_idle();
        repeat (3) tick();

        // Settled state: idle fetch at PC0 indexes ghr_spec directly; PHT[3] is weakly taken.
        check(32'(pht_idxD),   32'h003, "end_idx");
        check(32'(ghr_spec),   32'h03,  "end_ghr");
        check(32'(pred_takeD), 32'h1,   "end_pred");
        check(branch_cnt,      32'h0,   "end_bcnt");
        check(mispred_cnt,     32'h0,   "end_mcnt");

        while (sb.size() > 0) begin
            cur = sb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: never compared (due %0d, cycle %0d)", cur.name, cur.due, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_predict.md
# gshare_predict

Parametrised global-history branch direction predictor, successor to the fixed 6-bit GHR / 2-bit PHT predictor. It indexes a pattern history table of saturating counters and carries two history registers: a speculative GHR updated at fetch and an architectural GHR updated at memory stage. On a mispredict, the speculative history is repaired from the architectural GHR in one cycle. It sits beside the F/D pipeline registers of the MIPS core, and it exports the PHT index so the pipeline can carry it to M for the update.

## Interface
- `PC_WIDTH`, 32, fetch PC width
- `GHR_BITS`, 8, history length; must be ≤ `PHT_INDEX_BITS`
- `PHT_INDEX_BITS`, 10, PHT has 2^PHT_INDEX_BITS entries
- `CTR_BITS`, 2, saturating counter width (≥1)
- `CNT_WIDTH`, 32, statistics counter width
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high reset
- `stallD` in 1: hold the F→D register
- `flushD` in 1: clear the F→D register
- `pcF` in PC_WIDTH: fetch PC
- `branchF` in 1: the instruction in F is a conditional branch
- `branchD` in 1: the instruction in D is a conditional branch
- `branchM` in 1: a branch resolves in M
- `actual_takeM` in 1: resolved direction
- `errorM` in 1: the M branch was mispredicted
- `pht_idxM` in PHT_INDEX_BITS: index carried from D to M by the pipeline
- `pred_takeD` out 1: predicted direction for D
- `pht_idxD` out PHT_INDEX_BITS: index used for the D prediction
- `ghr_spec` out GHR_BITS: speculative GHR (debug)
- `branch_cnt` out CNT_WIDTH: resolved branches
- `mispred_cnt` out CNT_WIDTH: mispredicts

## Operation
- Index in F: `idxF = zext(ghr_spec) ^ pcF[PHT_INDEX_BITS+1:2]` (see Configuration). `pred_takeF = PHT[idxF][CTR_BITS-1]`.
- F→D register, holding `pred_takeF` and `idxF`:
  - `rst` or `flushD` → 0.
  - Otherwise `~stallD` → load.
  - Otherwise hold.
- `pred_takeD = branchD & pred_reg`. `pht_idxD` is the registered index.
- Speculative GHR, priority order:
  1. `rst` → 0.
  2. `errorM` → `{ghr_arch[GHR_BITS-2:0], actual_takeM}`.
  3. `branchF & ~stallD & ~flushD` → `{ghr_spec[GHR_BITS-2:0], pred_takeF}`.
  4. Otherwise hold.
- Architectural GHR: `rst` → 0; `branchM` → `{ghr_arch[GHR_BITS-2:0], actual_takeM}`.
- PHT, on `branchM` only:
  - `PHT[pht_idxM]` increments if taken, decrements if not.
  - Saturates at `2^CTR_BITS-1` and at 0.
  - `rst` sets all entries to `2^(CTR_BITS-1)` (weakly taken).
  - No write when `branchM=0`.
- Statistics:
  - `branch_cnt` increments on `branchM`.
  - `mispred_cnt` increments on `branchM & errorM`.
  - Both saturate at all-ones and reset to 0.
  - `errorM` without `branchM` is ignored by the counters but still repairs the GHR.

## Timing
- Reset values: `pred_takeD=0`, `pht_idxD=0`, `ghr_spec=0`, `branch_cnt=0`, `mispred_cnt=0`; all PHT entries weakly taken.
- Prediction latency: PHT is read combinationally in F; the result is visible in D one cycle later.
- PHT read/write to the same index in the same cycle: F reads the pre-update value (no bypass).
- Repair takes effect the cycle after `errorM`.
  - A `branchF` in the same cycle as `errorM` is dropped from history.
  - The pipeline flushes that F instruction anyway.
- `stallD` and `flushD` together: flush wins.
- `rst` asserted mid-operation overrides every other input on that edge.
- Counters and GHRs wrap only by shifting; no overflow exists beyond saturation.

## Configuration
- `GSHARE_PC_XOR_EN` defined: `idxF = zext(ghr_spec) ^ pcF[PHT_INDEX_BITS+1:2]` (gshare).
- `GSHARE_PC_XOR_EN` undefined: `idxF = zext(ghr_spec)` (pure global GAg); `pcF` is unused.

## Test plan
- **Reset prediction:** reset, then `branchF=1`, `pcF=0x00400010`, no stall; next cycle `branchD=1` → `pred_takeD=1`, `pht_idxD=0x004`, `ghr_spec=0x01`.
- **Not-taken training:** three `branchM=1`, `actual_takeM=0`, `pht_idxM=0x005` → counter goes 2→1→0→0. A later F read of index 5 predicts 0; `branch_cnt=3`.
- **Taken saturation:** four taken updates at index 0x3FF → counter is 3. One not-taken update → 2, still predicts taken.
- **Repair priority:** set `ghr_arch=0x0A`, `ghr_spec=0xFF`; assert `errorM=1`, `branchM=1`, `actual_takeM=1` with `branchF=1` in the same cycle → next cycle `ghr_spec=0x15`, `mispred_cnt` +1.
- **Stall/flush:**
  - `stallD=1` for 3 cycles with `branchF=1` → `pht_idxD` and `ghr_spec` are unchanged.
  - `flushD=1` together with `stallD=1` → `pred_takeD=0` and `pht_idxD=0` next cycle.
- **Macro off:** with `GSHARE_PC_XOR_EN` undefined, `ghr_spec=0x03`, `pcF=0xFFFFFFFC` → `pht_idxD=0x003`.
